// File: rtl/regfile_dump_pkg.sv
// regfile_dump_pkg: shared constants and FSM state type for the register-file dump engine.
package regfile_dump_pkg;
    localparam int RF_WIDTH      = 32;
    localparam int RF_ADDR_WIDTH = 5;
    typedef enum logic [2:0] {IDLE, LOAD, SEND_EVEN, SEND_ODD, DONE} dump_state_t;
endpackage

// File: rtl/regfile_dump.sv
// regfile_dump: sweeps the register file two words per access and streams address/data over valid/ready.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int WIDTH      = RF_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Start,
    output logic [ADDR_WIDTH-1:0] ReadRegister1,
    output logic [ADDR_WIDTH-1:0] ReadRegister2,
    input  logic [WIDTH-1:0]      ReadData1,
    input  logic [WIDTH-1:0]      ReadData2,
    output logic [WIDTH-1:0]      OutData,
    output logic [ADDR_WIDTH-1:0] OutAddr,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic                  Busy,
    output logic                  Done
);
    localparam logic [ADDR_WIDTH-2:0] LAST_PAIR = '1;
    dump_state_t           r_state, w_next;
    logic [ADDR_WIDTH-2:0] r_k;
    logic [WIDTH-1:0]      r_buf0, r_buf1;
    logic                  w_last;
    assign w_last = r_k == LAST_PAIR;
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_buf0  <= '0;
            r_buf1  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == LOAD) begin
                r_buf0 <= ReadData1;
                r_buf1 <= ReadData2;
            end
            // k saturates on the last pair and is cleared on the way back to IDLE
            if (r_state == SEND_ODD && OutReady && !w_last)
                r_k <= r_k + 1'b1;
            else if (r_state == DONE)
                r_k <= '0;
        end
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = Start ? LOAD : IDLE;
            LOAD:      w_next = SEND_EVEN;
            SEND_EVEN: w_next = OutReady ? SEND_ODD : SEND_EVEN;
            SEND_ODD:  w_next = !OutReady ? SEND_ODD : (w_last ? DONE : LOAD);
            DONE:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end
    assign ReadRegister1 = {r_k, 1'b0};
    assign ReadRegister2 = {r_k, 1'b1};
    assign OutValid      = r_state == SEND_EVEN || r_state == SEND_ODD;
    assign OutData       = (r_state == SEND_ODD) ? r_buf1 : r_buf0;
    assign OutAddr       = {r_k, r_state == SEND_ODD};
    assign Busy          = r_state != IDLE;
    assign Done          = r_state == DONE;
endmodule

// File: doc/regfile_dump.md
# regfile_dump

Sequential read-out engine for the 32×32 register file. On a `Start` pulse it sweeps every register address in ascending order, using both combinational read ports to fetch two registers per access. It streams each word with its address over a valid/ready interface. It sits between the register file's read ports and a debug/trace consumer, and is the reading counterpart to the register file's single write port.

## Interface
Parameters:
- `WIDTH`, 32, data word width; must match the register file.
- `ADDR_WIDTH`, 5, register address width; the sweep covers 2^ADDR_WIDTH registers (even count).

Ports:
- `Clk`  in  1  clock; all state changes on the rising edge.
- `Reset_n`  in  1  reset; asynchronous, active-low.
- `Start`  in  1  begin a sweep; sampled only in IDLE.
- `ReadRegister1`  out  ADDR_WIDTH  even address to register file read port 1.
- `ReadRegister2`  out  ADDR_WIDTH  odd address to register file read port 2.
- `ReadData1`  in  WIDTH  combinational data for `ReadRegister1`.
- `ReadData2`  in  WIDTH  combinational data for `ReadRegister2`.
- `OutData`  out  WIDTH  streamed register contents.
- `OutAddr`  out  ADDR_WIDTH  address of the word in `OutData`.
- `OutValid`  out  1  `OutData` and `OutAddr` are valid.
- `OutReady`  in  1  consumer accepts the word when it is high together with `OutValid`.
- `Busy`  out  1  a sweep is in progress (state is not IDLE).
- `Done`  out  1  one-cycle pulse after the last word is accepted.

## Operation
- The FSM has five states: IDLE, LOAD, SEND_EVEN, SEND_ODD, DONE.
- IDLE:
  - pair counter `k` = 0.
  - `Start`=1 → LOAD.
- LOAD:
  - `ReadRegister1` = 2k, `ReadRegister2` = 2k+1.
  - At the edge, `ReadData1` is captured into `buf0` and `ReadData2` into `buf1`.
  - → SEND_EVEN.
- SEND_EVEN:
  - `OutValid`=1, `OutData`=`buf0`, `OutAddr`=2k.
  - On `OutValid`&&`OutReady` → SEND_ODD.
- SEND_ODD:
  - `OutValid`=1, `OutData`=`buf1`, `OutAddr`=2k+1.
  - On handshake: if k = 2^(ADDR_WIDTH-1)-1 → DONE; otherwise k increments and the FSM goes to LOAD.
- DONE:
  - `Done`=1 for exactly one cycle.
  - → IDLE.
- Read addresses are driven from `k` in every state; in IDLE they are 0 and 1.
- Backpressure: while `OutValid`=1 and `OutReady`=0, `OutData`, `OutAddr` and the state hold unchanged.
- Snapshot rule:
  - Each pair is captured atomically in its LOAD cycle.
  - Writes to the register file during a sweep are seen by any pair not yet loaded.
  - No whole-file consistency is guaranteed.
- `Start` outside IDLE is ignored (this includes the DONE cycle).
- `OutAddr` arithmetic is unsigned. The counter `k` is ADDR_WIDTH-1 bits and is never allowed to wrap.

## Timing
- Reset (`Reset_n`=0, asynchronous):
  - State returns to IDLE and `k`=0.
  - `OutValid`=0, `Busy`=0, `Done`=0; `OutData`=0 and `OutAddr`=0 (registered).
  - `ReadRegister1`=0, `ReadRegister2`=1.
- Reset mid-sweep:
  - All outputs drop immediately, with no handshake completion.
  - The next `Start` restarts at address 0.
- Start-to-first-valid latency:
  - `Start` sampled at edge t0 → LOAD during t0..t1 → `OutValid` is high after t1.
  - That is 2 edges.
- Throughput with `OutReady` held at 1: 3 cycles per pair; a full 32-register sweep takes 48 cycles from the LOAD entry to the final handshake, plus 1 DONE cycle.
- `Busy` is high from the edge that samples `Start` through the DONE cycle inclusive.
- `OutValid` is a registered state decode: it is never combinationally dependent on `OutReady`.

## Structure
- Shared package `regfile_dump_pkg`:
  - state enum `dump_state_t` (IDLE, LOAD, SEND_EVEN, SEND_ODD, DONE).
  - constants `RF_WIDTH`=32, `RF_ADDR_WIDTH`=5.
- Single module with no sub-module: the pair buffer is two registers plus a select and does not justify one.
- The register file itself is not instantiated inside this block; it is connected at the parent level.

## Test plan
- Preload register r with 0xA500_0000|r via the write port, then pulse `Start` with `OutReady`=1 → 32 words, `OutAddr` 0..31 in order, `OutData` = 0xA500_0000|addr, `Done` pulses once, `Busy` high for 49 cycles.
- Same preload; hold `OutReady`=0 for 5 cycles while `OutAddr`=3 → `OutData`=0xA500_0003 and `OutAddr`=3 are stable for those cycles, and no word is lost or duplicated.
- Pulse `Start` again while `OutAddr`=7 → ignored: the sweep continues at 8 and exactly 32 words and one `Done` are produced in total.
- Deassert `Reset_n` while `OutAddr`=10 → `OutValid`, `Busy` and `Done` go to 0 immediately; a new `Start` yields a first word with `OutAddr`=0.
- Write 0xDEAD_BEEF to r20 during the cycle `OutAddr`=5 is being sent → the streamed r20 is 0xDEAD_BEEF; write 0x1 to r4 at the same point → the streamed r4 keeps its old value, since it was already loaded.
